pred_reg_file_pn: RTL and testbench

Parametrised predicate register file for a CGRA processing element, successor to the fixed 4-bit/64-entry/4-channel predicate store. It captures predicates arriving from NCH neighbour/bus channels and from FU write-back, and tracks a per-entry valid bit. It feeds the FU predicate input, either from the file or bypassed from a channel, and drives registered predicate outputs onto selected channels. An optional consume-on-send mode clears an entry's valid bit when it is forwarded.

---
 rtl/pred_reg_file_pn_if.sv | 43 ++++
 rtl/pred_reg_file_pn.sv | 177 +++++++++++++++++
 tb/tb_pred_reg_file_pn.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pred_reg_file_pn_if.sv
// Bus bundle for the predicate register file: capture, write-back, FU read,
// send and status signals. The design uses the slave side, the driver the master side.
interface pred_reg_file_pn_if #(
  parameter int WIDTH = 4,
  parameter int AW    = 6,
  parameter int NCH   = 4
);
  logic [NCH*WIDTH-1:0] ch_in_data;
  logic [NCH-1:0]       in_sel;
  logic                 in_en;
  logic [AW-1:0]        in_addr;
  logic                 write_back_p;
  logic [AW-1:0]        wb_addr;
  logic [WIDTH-1:0]     wb_data;
  logic [NCH-1:0]       pe2fu_sel;
  logic [AW-1:0]        pred_addr;
  logic [WIDTH-1:0]     pred_out;
  logic                 pred_valid;
  logic                 send_en;
  logic [AW-1:0]        send_addr;
  logic [NCH-1:0]       send_mask;
  logic                 send_clr;
  logic [NCH*WIDTH-1:0] ch_out_data;
  logic [NCH-1:0]       ch_out_valid;
  logic                 collide;
  logic                 sel_err;

  modport slave (
    input  ch_in_data, in_sel, in_en, in_addr,
    input  write_back_p, wb_addr, wb_data,
    input  pe2fu_sel, pred_addr,
    input  send_en, send_addr, send_mask, send_clr,
    output pred_out, pred_valid, ch_out_data, ch_out_valid, collide, sel_err
  );

  modport master (
    output ch_in_data, in_sel, in_en, in_addr,
    output write_back_p, wb_addr, wb_data,
    output pe2fu_sel, pred_addr,
    output send_en, send_addr, send_mask, send_clr,
    input  pred_out, pred_valid, ch_out_data, ch_out_valid, collide, sel_err
  );
endinterface

// File: rtl/pred_reg_file_pn.sv
// Predicate register file for a CGRA PE: channel capture, FU write-back,
// FU read with channel bypass, and registered multi-channel send with optional consume.
module pred_reg_file_pn #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int NCH   = 4
) (
  input logic             CLK,
  input logic             RST,
  pred_reg_file_pn_if.slave bus
);

  localparam logic [AW:0]    DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [NCH-1:0] ONE_L   = {{(NCH-1){1'b0}}, 1'b1};

  function automatic logic is_one_hot(input logic [NCH-1:0] v);
    return (v != {NCH{1'b0}}) && ((v & (v - ONE_L)) == {NCH{1'b0}});
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [DEPTH-1:0]     valid_r;
  logic [NCH*WIDTH-1:0] ch_out_data_r;
  logic [NCH-1:0]       ch_out_valid_r;
  logic                 collide_r;
  logic                 sel_err_r;

  logic                 in_oh_s;
  logic                 pe_oh_s;
  logic                 pe_multi_s;
  logic                 cap_req_s;
  logic                 wb_req_s;
  logic                 collide_s;
  logic                 cap_wr_s;
  logic                 clr_s;
  logic                 sel_err_s;
  logic [WIDTH-1:0]     cap_data_s;
  logic [WIDTH-1:0]     byp_data_s;
  logic [WIDTH-1:0]     send_data_s;
  logic                 send_valid_s;
  logic [WIDTH-1:0]     pred_out_s;
  logic                 pred_valid_s;
  logic [NCH*WIDTH-1:0] ch_out_data_s;
  logic [NCH-1:0]       ch_out_valid_s;

  // Write arbitration: write-back beats a capture to the same entry.
  always_comb begin
    in_oh_s    = is_one_hot(bus.in_sel);
    pe_oh_s    = is_one_hot(bus.pe2fu_sel);
    pe_multi_s = (bus.pe2fu_sel != {NCH{1'b0}}) && !pe_oh_s;
    cap_req_s  = bus.in_en && in_oh_s && in_range(bus.in_addr);
    wb_req_s   = bus.write_back_p && in_range(bus.wb_addr);
    collide_s  = cap_req_s && wb_req_s && (bus.in_addr == bus.wb_addr);
    cap_wr_s   = cap_req_s && !collide_s;
    sel_err_s  = (bus.in_en && !in_oh_s) || pe_multi_s;
  end

  // One-hot channel muxes for capture data and FU bypass data.
  always_comb begin
    cap_data_s = {WIDTH{1'b0}};
    byp_data_s = {WIDTH{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (bus.in_sel[k]) begin
        cap_data_s = cap_data_s | bus.ch_in_data[k*WIDTH +: WIDTH];
      end else begin
        cap_data_s = cap_data_s;
      end
      if (bus.pe2fu_sel[k]) begin
        byp_data_s = byp_data_s | bus.ch_in_data[k*WIDTH +: WIDTH];
      end else begin
        byp_data_s = byp_data_s;
      end
    end
  end

  // FU read port; out-of-range and invalid entries read as zero.
  always_comb begin
    pred_out_s   = {WIDTH{1'b0}};
    pred_valid_s = 1'b0;
    if (pe_oh_s) begin
      pred_out_s   = byp_data_s;
      pred_valid_s = 1'b1;
    end else if (bus.pe2fu_sel == {NCH{1'b0}}) begin
      if (in_range(bus.pred_addr) && valid_r[bus.pred_addr]) begin
        pred_out_s   = mem_r[bus.pred_addr];
        pred_valid_s = 1'b1;
      end else begin
        pred_out_s   = {WIDTH{1'b0}};
        pred_valid_s = 1'b0;
      end
    end else begin
      pred_out_s   = {WIDTH{1'b0}};
      pred_valid_s = 1'b0;
    end
  end

  // Send source read and per-channel next output values.
  always_comb begin
    send_data_s    = {WIDTH{1'b0}};
    send_valid_s   = 1'b0;
    ch_out_data_s  = {(NCH*WIDTH){1'b0}};
    ch_out_valid_s = {NCH{1'b0}};
    if (in_range(bus.send_addr)) begin
      send_data_s  = mem_r[bus.send_addr];
      send_valid_s = valid_r[bus.send_addr];
    end else begin
      send_data_s  = {WIDTH{1'b0}};
      send_valid_s = 1'b0;
    end
    for (int k = 0; k < NCH; k++) begin
      if (bus.send_en && bus.send_mask[k]) begin
        ch_out_data_s[k*WIDTH +: WIDTH] = send_data_s;
        ch_out_valid_s[k]               = send_valid_s;
      end else begin
        ch_out_data_s[k*WIDTH +: WIDTH] = {WIDTH{1'b0}};
        ch_out_valid_s[k]               = 1'b0;
      end
    end
    clr_s = bus.send_en && bus.send_clr && send_valid_s;
  end

  // Data array: not reset, writes suppressed while RST is high.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (cap_wr_s) begin
        mem_r[bus.in_addr] <= cap_data_s;
      end
      if (wb_req_s) begin
        mem_r[bus.wb_addr] <= bus.wb_data;
      end
    end
  end

  // Valid vector: consume clear first so a same-cycle write re-validates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      if (clr_s) begin
        valid_r[bus.send_addr] <= 1'b0;
      end
      if (cap_wr_s) begin
        valid_r[bus.in_addr] <= 1'b1;
      end
      if (wb_req_s) begin
        valid_r[bus.wb_addr] <= 1'b1;
      end
    end
  end

  // Registered channel outputs and status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ch_out_data_r  <= {(NCH*WIDTH){1'b0}};
      ch_out_valid_r <= {NCH{1'b0}};
      collide_r      <= 1'b0;
      sel_err_r      <= 1'b0;
    end else begin
      ch_out_data_r  <= ch_out_data_s;
      ch_out_valid_r <= ch_out_valid_s;
      collide_r      <= collide_s;
      sel_err_r      <= sel_err_s;
    end
  end

  assign bus.pred_out     = pred_out_s;
  assign bus.pred_valid   = pred_valid_s;
  assign bus.ch_out_data  = ch_out_data_r;
  assign bus.ch_out_valid = ch_out_valid_r;
  assign bus.collide      = collide_r;
  assign bus.sel_err      = sel_err_r;

endmodule

// File: tb/tb_pred_reg_file_pn.sv
// Directed, table-driven bench for pred_reg_file_pn plus hand-written
// sequences for send/consume, write races and reset.
module tb_pred_reg_file_pn;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pred_reg_file_pn_if #(.WIDTH(4), .AW(6), .NCH(4)) bus ();

  pred_reg_file_pn #(.WIDTH(4), .DEPTH(64), .AW(6), .NCH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       wb_en;
    logic [5:0] wb_addr;
    logic [3:0] wb_data;
    logic       in_en;
    logic [3:0] in_sel;
    logic [5:0] in_addr;
    logic [15:0] ch;
    logic [5:0] rd_addr;
    logic [3:0] pe_sel;
    logic [3:0] e_pred;
    logic       e_valid;
    logic       e_sel_err;
    logic       e_collide;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.ch_in_data   = 16'h0000;
    bus.in_sel       = 4'b0000;
    bus.in_en        = 1'b0;
    bus.in_addr      = 6'd0;
    bus.write_back_p = 1'b0;
    bus.wb_addr      = 6'd0;
    bus.wb_data      = 4'h0;
    bus.pe2fu_sel    = 4'b0000;
    bus.pred_addr    = 6'd0;
    bus.send_en      = 1'b0;
    bus.send_addr    = 6'd0;
    bus.send_mask    = 4'b0000;
    bus.send_clr     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string name, input logic [5:0] a,
                          input logic [3:0] ep, input logic ev);
    bus.pe2fu_sel = 4'b0000;
    bus.pred_addr = a;
    #1;
    chk({name, ".pred"}, {28'd0, bus.pred_out}, {28'd0, ep});
    chk({name, ".valid"}, {31'd0, bus.pred_valid}, {31'd0, ev});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //        wb  wbA    wbD   in inSel    inA    ch        rd     pe       pred  v     se    col
    vecs[0]  = '{1'b1, 6'd5,  4'hA, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd5,  4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd5,  4'b0000, 4'hA, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd6,  4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 6'd0,  4'h0, 1'b1, 4'b0100, 6'd9,  16'h0300, 6'd9,  4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 6'd0,  4'h0, 1'b1, 4'b0110, 6'd10, 16'h0300, 6'd9,  4'b0000, 4'h3, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd10, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 6'd12, 4'h7, 1'b1, 4'b0001, 6'd12, 16'h0001, 6'd12, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd12, 4'b0000, 4'h7, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 6'd21, 4'hB, 1'b1, 4'b0010, 6'd20, 16'h50E0, 6'd9,  4'b1000, 4'h5, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd20, 4'b0000, 4'hE, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd21, 4'b0000, 4'hB, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h1234, 6'd21, 4'b0011, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd63, 4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 6'd3,  4'hC, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd3,  4'b0000, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 6'd0,  4'h0, 1'b0, 4'b0000, 6'd0,  16'h0000, 6'd3,  4'b0000, 4'hC, 1'b1, 1'b0, 1'b0};

    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst.ch_out_data", {16'd0, bus.ch_out_data}, 32'h0);
    chk("rst.ch_out_valid", {28'd0, bus.ch_out_valid}, 32'h0);
    chk("rst.collide", {31'd0, bus.collide}, 32'h0);
    chk("rst.sel_err", {31'd0, bus.sel_err}, 32'h0);
    rst = 1'b0;
    read_chk("rst.read0", 6'd0, 4'h0, 1'b0);

    // Reads are checked before the edge so they see pre-write contents.
    for (int i = 0; i < 15; i++) begin
      bus.write_back_p = vecs[i].wb_en;
      bus.wb_addr      = vecs[i].wb_addr;
      bus.wb_data      = vecs[i].wb_data;
      bus.in_en        = vecs[i].in_en;
      bus.in_sel       = vecs[i].in_sel;
      bus.in_addr      = vecs[i].in_addr;
      bus.ch_in_data   = vecs[i].ch;
      bus.pred_addr    = vecs[i].rd_addr;
      bus.pe2fu_sel    = vecs[i].pe_sel;
      #1;
      chk($sformatf("vec%0d.pred_out", i), {28'd0, bus.pred_out}, {28'd0, vecs[i].e_pred});
      chk($sformatf("vec%0d.pred_valid", i), {31'd0, bus.pred_valid}, {31'd0, vecs[i].e_valid});
      step();
      chk($sformatf("vec%0d.sel_err", i), {31'd0, bus.sel_err}, {31'd0, vecs[i].e_sel_err});
      chk($sformatf("vec%0d.collide", i), {31'd0, bus.collide}, {31'd0, vecs[i].e_collide});
    end
    idle();

    // Send with consume: entry 3 = C.
    bus.send_en   = 1'b1;
    bus.send_addr = 6'd3;
    bus.send_mask = 4'b1001;
    bus.send_clr  = 1'b1;
    read_chk("send.pre", 6'd3, 4'hC, 1'b1);
    step();
    idle();
    chk("send.data", {16'd0, bus.ch_out_data}, 32'h0000C00C);
    chk("send.valid", {28'd0, bus.ch_out_valid}, 32'h9);
    read_chk("send.consumed", 6'd3, 4'h0, 1'b0);
    step();
    chk("send.pulse_data", {16'd0, bus.ch_out_data}, 32'h0);
    chk("send.pulse_valid", {28'd0, bus.ch_out_valid}, 32'h0);

    // Send without consume keeps the entry.
    bus.send_en   = 1'b1;
    bus.send_addr = 6'd21;
    bus.send_mask = 4'b0100;
    step();
    idle();
    chk("keep.data", {16'd0, bus.ch_out_data}, 32'h00000B00);
    chk("keep.valid", {28'd0, bus.ch_out_valid}, 32'h4);
    read_chk("keep.entry", 6'd21, 4'hB, 1'b1);

    // Consume racing a write-back to the same entry.
    bus.write_back_p = 1'b1;
    bus.wb_addr      = 6'd3;
    bus.wb_data      = 4'hC;
    step();
    bus.wb_data   = 4'h5;
    bus.send_en   = 1'b1;
    bus.send_addr = 6'd3;
    bus.send_mask = 4'b0010;
    bus.send_clr  = 1'b1;
    step();
    idle();
    chk("race.data", {16'd0, bus.ch_out_data}, 32'h000000C0);
    chk("race.valid", {28'd0, bus.ch_out_valid}, 32'h2);
    read_chk("race.entry", 6'd3, 4'h5, 1'b1);

    // Fill ten entries, then reset while a send is on the outputs.
    for (int i = 0; i < 10; i++) begin
      bus.write_back_p = 1'b1;
      bus.wb_addr      = 6'(30 + i);
      bus.wb_data      = 4'(i + 1);
      step();
    end
    idle();
    read_chk("fill.entry35", 6'd35, 4'h6, 1'b1);
    bus.send_en   = 1'b1;
    bus.send_addr = 6'd30;
    bus.send_mask = 4'b1111;
    step();
    chk("fill.send_data", {16'd0, bus.ch_out_data}, 32'h00001111);
    chk("fill.send_valid", {28'd0, bus.ch_out_valid}, 32'hF);
    rst              = 1'b1;
    bus.write_back_p = 1'b1;
    bus.wb_addr      = 6'd40;
    bus.wb_data      = 4'hF;
    bus.in_en        = 1'b1;
    bus.in_sel       = 4'b0011;
    step();
    rst = 1'b0;
    idle();
    chk("rst2.ch_out_data", {16'd0, bus.ch_out_data}, 32'h0);
    chk("rst2.ch_out_valid", {28'd0, bus.ch_out_valid}, 32'h0);
    chk("rst2.sel_err", {31'd0, bus.sel_err}, 32'h0);
    chk("rst2.collide", {31'd0, bus.collide}, 32'h0);
    for (int a = 0; a < 64; a++) begin
      read_chk($sformatf("rst2.read%0d", a), 6'(a), 4'h0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
